// File: rtl/gate_lab_pkg.sv
// Shared types and constants for the switch conditioner in front of the gate lab.
// Holds the per-channel debounce FSM encoding and the default/simulation debounce lengths.
package gate_lab_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } db_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int SIM_DEBOUNCE_CYCLES = 4;

    // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, stability counter and 4-state debounce FSM.
// Clean level and edge pulses are all registered.
module debounce_channel
    import gate_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int CNT_WIDTH = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0]           sync_q;
    logic                 s;
    db_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 clean_q, clean_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Counter only advances while waiting; every other path clears it, so any reversion restarts the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            STABLE_LOW: begin
                if (s) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!s)                  state_d = STABLE_LOW;
                else if (cnt_q == CNT_LAST) state_d = STABLE_HIGH;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            STABLE_HIGH: begin
                if (!s) state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (s)                   state_d = STABLE_HIGH;
                else if (cnt_q == CNT_LAST) state_d = STABLE_LOW;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = STABLE_LOW;
        endcase
    end

    always_comb begin
        clean_d = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
        rise_d  = (state_q == WAIT_HIGH) && (state_d == STABLE_HIGH);
        fall_d  = (state_q == WAIT_LOW) && (state_d == STABLE_LOW);
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Two independent debounce channels feeding the logic-gate stage inputs A and B.
// Wiring only; all behaviour lives in debounce_channel.
module input_debouncer
    import gate_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic A_Raw,
    input  logic B_Raw,
    output logic A_Clean,
    output logic B_Clean,
    output logic A_Rise,
    output logic A_Fall,
    output logic B_Rise,
    output logic B_Fall
);

    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0] raw, clean, rise, fall;

    assign raw = {B_Raw, A_Raw};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (Clk),
            .rst_n(Rst_n),
            .raw  (raw[i]),
            .clean(clean[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign A_Clean = clean[0];
    assign B_Clean = clean[1];
    assign A_Rise  = rise[0];
    assign B_Rise  = rise[1];
    assign A_Fall  = fall[0];
    assign B_Fall  = fall[1];

endmodule
